// File: rtl/inst_rom_loader.sv
// Instruction memory with a boot loader: packs a little-endian byte stream into
// 32-bit words, holds the core in reset until the load completes, then serves fetches.
module inst_rom_loader #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = 12,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    byte_i,
  input  logic          byte_valid_i,
  output logic          byte_ready_o,
  input  logic          reload_i,
  input  logic [31:0]   inst_addr_i,
  output logic [31:0]   inst_o,
  output logic          core_rst_o,
  output logic          load_done_o,
  output logic          load_err_o,
  output logic [AW:0]   words_loaded_o
);

  typedef enum logic [1:0] {SLen, SData, SDone, SErr} state_e;

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [AW:0] len_q, len_d;
  logic [AW:0] word_cnt_q, word_cnt_d;
  logic [31:0] shreg_q, shreg_d;
  logic [31:0] word;
  logic        accept;
  logic        last_byte;
  logic        mem_we;
  logic        unused_addr_bits;

  logic [31:0] mem [DEPTH];

  assign byte_ready_o = (state_q == SLen) || (state_q == SData);
  assign accept       = byte_valid_i && byte_ready_o;
  assign last_byte    = accept && (byte_cnt_q == 2'd3);
  // The fourth byte completes the word in the same cycle it is accepted.
  assign word         = {byte_i, shreg_q[23:0]};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    shreg_d    = shreg_q;
    mem_we     = 1'b0;
    if (accept) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      shreg_d[8*byte_cnt_q +: 8] = byte_i;
    end
    unique case (state_q)
      SLen: begin
        if (last_byte) begin
          if (word == 32'd0) begin
            state_d = SDone;
          end else if (word > DEPTH) begin
            state_d = SErr;
          end else begin
            state_d    = SData;
            len_d      = word[AW:0];
            word_cnt_d = '0;
          end
        end
      end
      SData: begin
        if (last_byte) begin
          mem_we     = 1'b1;
          word_cnt_d = word_cnt_q + {{AW{1'b0}}, 1'b1};
          if (word_cnt_d == len_q) state_d = SDone;
        end
      end
      SDone: begin
        if (reload_i) begin
          state_d    = SLen;
          byte_cnt_d = '0;
          word_cnt_d = '0;
        end
      end
      SErr: begin
        state_d = SErr;
      end
      default: state_d = SLen;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SLen;
      byte_cnt_q <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      shreg_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      shreg_q    <= shreg_d;
    end
  end

  // Array is deliberately not reset so a reset mid-load keeps written words.
  always_ff @(posedge clk) begin
    if (mem_we) mem[word_cnt_q[AW-1:0]] <= word;
  end

  always_comb begin
    inst_o = NOP;
    if (inst_addr_i[31:AW+2] == '0) inst_o = mem[inst_addr_i[AW+1:2]];
  end

  assign unused_addr_bits = ^inst_addr_i[1:0];
  assign core_rst_o       = (state_q == SDone);
  assign load_done_o      = (state_q == SDone);
  assign load_err_o       = (state_q == SErr);
  assign words_loaded_o   = word_cnt_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed + randomized bench for inst_rom_loader with an array-based reference
// of the instruction memory and expected load outcomes.
module tb_inst_rom_loader;

  localparam int unsigned AW = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic        reload_i = 1'b0;
  logic [31:0] inst_addr_i = 32'h0;
  logic [31:0] inst_o;
  logic        core_rst_o;
  logic        load_done_o;
  logic        load_err_o;
  logic [AW:0] words_loaded_o;

  int tests = 0;
  int fails = 0;

  logic [31:0] ref_mem   [64];
  logic        ref_valid [64];
  logic [7:0]  stream_q  [$];

  inst_rom_loader dut (
    .clk            (clk),
    .rst            (rst),
    .byte_i         (byte_i),
    .byte_valid_i   (byte_valid_i),
    .byte_ready_o   (byte_ready_o),
    .reload_i       (reload_i),
    .inst_addr_i    (inst_addr_i),
    .inst_o         (inst_o),
    .core_rst_o     (core_rst_o),
    .load_done_o    (load_done_o),
    .load_err_o     (load_err_o),
    .words_loaded_o (words_loaded_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    inst_addr_i = addr;
    #1;
    check(tag, inst_o, exp);
  endtask

  task automatic check_mem();
    for (int i = 0; i < 64; i++)
      if (ref_valid[i]) fetch($sformatf("mem[%0d]", i), i * 4, ref_mem[i]);
  endtask

  task automatic send_byte(input logic [7:0] b, input int idle);
    repeat (idle) begin
      @(posedge clk);
      #1;
    end
    byte_i       = b;
    byte_valid_i = 1'b1;
    @(posedge clk);
    #1;
    byte_valid_i = 1'b0;
    byte_i       = 8'($urandom);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) stream_q.push_back(w[8*k +: 8]);
  endtask

  // Streams the queued bytes; core must stay in reset up to the final accept.
  task automatic run_stream(input int max_idle, input bit expect_done);
    int idle;
    while (stream_q.size() > 0) begin
      idle = (max_idle == 0) ? 0 : int'($urandom_range(1, max_idle));
      if (stream_q.size() == 1 && expect_done) begin
        repeat (idle) begin
          @(posedge clk);
          #1;
        end
        idle = 0;
        check("core_rst_before_last", {31'd0, core_rst_o}, 32'd0);
      end
      send_byte(stream_q.pop_front(), idle);
    end
    if (expect_done) begin
      check("core_rst_after_last", {31'd0, core_rst_o}, 32'd1);
      check("load_done_after_last", {31'd0, load_done_o}, 32'd1);
      check("ready_in_done", {31'd0, byte_ready_o}, 32'd0);
    end
  endtask

  task automatic pulse_reload();
    reload_i = 1'b1;
    @(posedge clk);
    #1;
    reload_i = 1'b0;
    check("reload_core_rst", {31'd0, core_rst_o}, 32'd0);
    check("reload_ready", {31'd0, byte_ready_o}, 32'd1);
    check("reload_words", 32'(words_loaded_o), 32'd0);
  endtask

  // Model: a load of n words sets ref_mem[0..n-1]; everything else is retained.
  task automatic model_load(input int n, input logic [31:0] w [16]);
    for (int i = 0; i < n; i++) begin
      ref_mem[i]   = w[i];
      ref_valid[i] = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] words [16];
    int n;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i]   = 32'h0;
      ref_valid[i] = 1'b0;
    end

    // Reset state
    #3;
    check("rst_ready", {31'd0, byte_ready_o}, 32'd1);
    check("rst_core_rst", {31'd0, core_rst_o}, 32'd0);
    check("rst_done", {31'd0, load_done_o}, 32'd0);
    check("rst_err", {31'd0, load_err_o}, 32'd0);
    check("rst_words", 32'(words_loaded_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Test 1: four-word program with an idle cycle after the length
    send_byte(8'h04, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    @(posedge clk);
    #1;
    words[0] = 32'h00100513; words[1] = 32'h00100513;
    words[2] = 32'h00200593; words[3] = 32'h0000006f;
    for (int i = 0; i < 4; i++) push_word(words[i]);
    model_load(4, words);
    run_stream(0, 1'b1);
    check("t1_words", 32'(words_loaded_o), 32'd4);
    check_mem();

    // Test 6: fetch addressing
    fetch("fetch_0c", 32'h0000000C, 32'h0000006f);
    fetch("fetch_0e", 32'h0000000E, 32'h0000006f);
    fetch("fetch_oor", 32'h00004000, 32'h00000013);
    fetch("fetch_oor_rand", {$urandom_range(1, 32'h3FFFF), 14'($urandom)}, 32'h00000013);

    // Test 5: reload one word, later words retained
    pulse_reload();
    words[0] = 32'hDEADBEEF;
    push_word(32'd1);
    push_word(words[0]);
    model_load(1, words);
    run_stream(0, 1'b1);
    check("t5_words", 32'(words_loaded_o), 32'd1);
    check_mem();

    // Test 2: zero-length load
    pulse_reload();
    push_word(32'd0);
    run_stream(0, 1'b1);
    check("t2_words", 32'(words_loaded_o), 32'd0);
    check_mem();

    // Test 4: random programs with random gaps between bytes
    for (int r = 0; r < 4; r++) begin
      pulse_reload();
      n = int'($urandom_range(1, 12));
      push_word(32'(n));
      for (int i = 0; i < n; i++) begin
        words[i] = $urandom;
        push_word(words[i]);
      end
      model_load(n, words);
      run_stream(5, 1'b1);
      check("t4_words", 32'(words_loaded_o), 32'(n));
      check_mem();
    end

    // Reset after six data bytes: first word kept, partial word dropped
    pulse_reload();
    words[0] = $urandom;
    push_word(32'd2);
    push_word(words[0]);
    stream_q.push_back(8'hAA);
    stream_q.push_back(8'hBB);
    model_load(1, words);
    run_stream(0, 1'b0);
    check("mid_words", 32'(words_loaded_o), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, byte_ready_o}, 32'd1);
    check("mid_rst_core_rst", {31'd0, core_rst_o}, 32'd0);
    check("mid_rst_words", 32'(words_loaded_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_mem();
    words[0] = $urandom;
    push_word(32'd1);
    push_word(words[0]);
    model_load(1, words);
    run_stream(0, 1'b1);
    check("post_rst_words", 32'(words_loaded_o), 32'd1);
    check_mem();

    // N == DEPTH is accepted and enters the data phase
    pulse_reload();
    push_word(32'd4096);
    run_stream(0, 1'b0);
    check("depth_ready", {31'd0, byte_ready_o}, 32'd1);
    check("depth_err", {31'd0, load_err_o}, 32'd0);
    check("depth_done", {31'd0, load_done_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Test 3: N == DEPTH+1 is an error, sticky against bytes and reload
    push_word(32'd4097);
    run_stream(0, 1'b0);
    check("err_flag", {31'd0, load_err_o}, 32'd1);
    check("err_core_rst", {31'd0, core_rst_o}, 32'd0);
    check("err_ready", {31'd0, byte_ready_o}, 32'd0);
    send_byte(8'h55, 0);
    reload_i = 1'b1;
    @(posedge clk);
    #1;
    reload_i = 1'b0;
    check("err_sticky", {31'd0, load_err_o}, 32'd1);
    check("err_sticky_ready", {31'd0, byte_ready_o}, 32'd0);
    check("err_done", {31'd0, load_done_o}, 32'd0);
    check_mem();
    rst = 1'b0;
    #1;
    check("err_cleared", {31'd0, load_err_o}, 32'd0);
    check("err_rst_ready", {31'd0, byte_ready_o}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
